// File: rtl/branch_update_queue_if.sv
// Bundle of alloc/resolve/commit/mispredict signals and the predictor update port.
// Optional BUQ_COM_HIST_EN adds OUT_comHist.
interface branch_update_queue_if #(
  parameter int DEPTH  = 16,
  parameter int HIST_W = 16,
  parameter int BPI_W  = 12
);
  localparam int TW = $clog2(DEPTH) + 1;

  logic              IN_allocValid;
  logic [30:0]       IN_allocPc;
  logic [HIST_W-1:0] IN_allocHist;
  logic [BPI_W-1:0]  IN_allocBpi;
  logic              IN_allocIsJump;
  logic [TW-1:0]     OUT_allocTag;
  logic              OUT_full;
  logic              IN_resValid;
  logic [TW-1:0]     IN_resTag;
  logic              IN_resTaken;
  logic              IN_comValid;
  logic [TW-1:0]     IN_comTag;
  logic              IN_mispr;
  logic [TW-1:0]     IN_misprTag;
  logic [HIST_W+BPI_W+32:0] OUT_bpUpdate;
`ifdef BUQ_COM_HIST_EN
  logic [HIST_W-1:0] OUT_comHist;

  modport master (
    output IN_allocValid, IN_allocPc, IN_allocHist, IN_allocBpi, IN_allocIsJump,
           IN_resValid, IN_resTag, IN_resTaken, IN_comValid, IN_comTag,
           IN_mispr, IN_misprTag,
    input  OUT_allocTag, OUT_full, OUT_bpUpdate, OUT_comHist
  );
  modport slave (
    input  IN_allocValid, IN_allocPc, IN_allocHist, IN_allocBpi, IN_allocIsJump,
           IN_resValid, IN_resTag, IN_resTaken, IN_comValid, IN_comTag,
           IN_mispr, IN_misprTag,
    output OUT_allocTag, OUT_full, OUT_bpUpdate, OUT_comHist
  );
`else
  modport master (
    output IN_allocValid, IN_allocPc, IN_allocHist, IN_allocBpi, IN_allocIsJump,
           IN_resValid, IN_resTag, IN_resTaken, IN_comValid, IN_comTag,
           IN_mispr, IN_misprTag,
    input  OUT_allocTag, OUT_full, OUT_bpUpdate
  );
  modport slave (
    input  IN_allocValid, IN_allocPc, IN_allocHist, IN_allocBpi, IN_allocIsJump,
           IN_resValid, IN_resTag, IN_resTaken, IN_comValid, IN_comTag,
           IN_mispr, IN_misprTag,
    output OUT_allocTag, OUT_full, OUT_bpUpdate
  );
`endif
endinterface

// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches; drains resolved+committed entries to the predictor.
// Optional BUQ_COM_HIST_EN adds a committed-history shift register on OUT_comHist.
module branch_update_queue #(
  parameter int DEPTH  = 16,
  parameter int HIST_W = 16,
  parameter int BPI_W  = 12
) (
  input logic clk,
  input logic rst,
  branch_update_queue_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     head, tail, cnt, res_off, com_off, mis_off;
  logic [IW-1:0]     h_idx, t_idx, r_idx;
  logic              full, alloc_ok, res_hit, com_hit, drain;
  logic [DEPTH-1:0]  resolved, committed, taken, com_set;
  logic [30:0]       pc_q   [DEPTH];
  logic [HIST_W-1:0] hist_q [DEPTH];
  logic [BPI_W-1:0]  bpi_q  [DEPTH];
  logic              bp_vld, bp_taken;
  logic [30:0]       bp_pc;
  logic [HIST_W-1:0] bp_hist;
  logic [BPI_W-1:0]  bp_bpi;

  assign h_idx = head[IW-1:0];
  assign t_idx = tail[IW-1:0];
  assign r_idx = bus.IN_resTag[IW-1:0];
  assign cnt   = tail - head;
  assign full  = (h_idx == t_idx) && (head[IW] != tail[IW]);

  assign alloc_ok = bus.IN_allocValid && !full && !bus.IN_mispr;

  // Offsets from head make the live-window test a single unsigned compare.
  assign res_off = bus.IN_resTag - head;
  assign com_off = bus.IN_comTag - head;
  assign mis_off = bus.IN_misprTag - head;
  assign res_hit = bus.IN_resValid && (res_off < cnt) &&
                   (!bus.IN_mispr || (res_off <= mis_off));
  assign com_hit = bus.IN_comValid && (com_off < cnt);
  assign drain   = (cnt != '0) && resolved[h_idx] && committed[h_idx];

  always_comb begin
    com_set = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (com_hit && ({1'b0, IW'(i) - h_idx} <= com_off)) com_set[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      resolved  <= '0;
      committed <= '0;
      taken     <= '0;
    end else begin
      if (drain) head <= head + 1'b1;
      if (bus.IN_mispr)  tail <= bus.IN_misprTag + 1'b1;
      else if (alloc_ok) tail <= tail + 1'b1;
      if (res_hit) begin
        resolved[r_idx] <= 1'b1;
        taken[r_idx]    <= bus.IN_resTaken;
      end
      committed <= committed | com_set;
      // Slot at tail is never live, so this cannot collide with resolve/commit.
      if (alloc_ok) begin
        resolved[t_idx]  <= bus.IN_allocIsJump;
        taken[t_idx]     <= bus.IN_allocIsJump;
        committed[t_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      pc_q[t_idx]   <= bus.IN_allocPc;
      hist_q[t_idx] <= bus.IN_allocHist;
      bpi_q[t_idx]  <= bus.IN_allocBpi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bp_vld <= 1'b0;
    else     bp_vld <= drain;
  end

  always_ff @(posedge clk) begin
    bp_pc    <= pc_q[h_idx];
    bp_hist  <= hist_q[h_idx];
    bp_bpi   <= bpi_q[h_idx];
    bp_taken <= taken[h_idx];
  end

  assign bus.OUT_bpUpdate = {bp_vld, bp_pc, bp_hist, bp_bpi, bp_taken};
  assign bus.OUT_allocTag = tail;
  assign bus.OUT_full     = full;

`ifdef BUQ_COM_HIST_EN
  logic [DEPTH-1:0]  is_jump;
  logic [HIST_W-1:0] com_hist;

  always_ff @(posedge clk) begin
    if (alloc_ok) is_jump[t_idx] <= bus.IN_allocIsJump;
  end

  // Only conditional branches feed the committed history.
  always_ff @(posedge clk) begin
    if (rst) com_hist <= '0;
    else if (drain && !is_jump[h_idx]) com_hist <= {com_hist[HIST_W-2:0], taken[h_idx]};
  end

  assign bus.OUT_comHist = com_hist;
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: cycle table plus corner-case sequences.
module tb_branch_update_queue;
  localparam int DEPTH = 16;
  localparam int HW    = 16;
  localparam int BW    = 12;
  localparam int TW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_update_queue_if #(.DEPTH(DEPTH), .HIST_W(HW), .BPI_W(BW)) bus ();
  branch_update_queue #(.DEPTH(DEPTH), .HIST_W(HW), .BPI_W(BW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit av; bit aj; int an;
    bit rv; int rt; bit rk;
    bit cv; int ct;
    bit mv; int mt;
    int etag; bit evld; int en; bit etk;
  } vec_t;
  vec_t vq[$];

  function automatic logic [30:0] pc_of(int n);   return 31'(32'h0004_0000 + n * 7); endfunction
  function automatic logic [HW-1:0] hist_of(int n); return HW'(n * 37 + 5); endfunction
  function automatic logic [BW-1:0] bpi_of(int n);  return BW'(n * 11 + 3); endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_bp(input string nm, input bit ev, input int en, input bit ek);
    logic [HW+BW+32:0] bp;
    bp = bus.OUT_bpUpdate;
    chk({nm, ".vld"}, 64'(bp[HW+BW+32]), 64'(ev));
    if (ev) begin
      chk({nm, ".pc"},    64'(bp[HW+BW+31:HW+BW+1]), 64'(pc_of(en)));
      chk({nm, ".hist"},  64'(bp[HW+BW:BW+1]),       64'(hist_of(en)));
      chk({nm, ".bpi"},   64'(bp[BW:1]),             64'(bpi_of(en)));
      chk({nm, ".taken"}, 64'(bp[0]),                64'(ek));
    end
  endtask

  task automatic drive(input bit av, input bit aj, input int an, input bit rv, input int rt,
                       input bit rk, input bit cv, input int ct, input bit mv, input int mt);
    bus.IN_allocValid  = av;
    bus.IN_allocIsJump = aj;
    bus.IN_allocPc     = pc_of(an);
    bus.IN_allocHist   = hist_of(an);
    bus.IN_allocBpi    = bpi_of(an);
    bus.IN_resValid    = rv;
    bus.IN_resTag      = TW'(rt);
    bus.IN_resTaken    = rk;
    bus.IN_comValid    = cv;
    bus.IN_comTag      = TW'(ct);
    bus.IN_mispr       = mv;
    bus.IN_misprTag    = TW'(mt);
  endtask

  task automatic idle();                    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alloc(input int n, input bit j); drive(1, j, n, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic step(); @(posedge clk); #1; endtask

  task automatic add(input bit av, input int an, input bit rv, input int rt, input bit rk,
                     input bit cv, input int ct, input bit mv, input int mt,
                     input int etag, input bit evld, input int en, input bit etk);
    vec_t v;
    v = '{av, 1'b0, an, rv, rt, rk, cv, ct, mv, mt, etag, evld, en, etk};
    vq.push_back(v);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    chk_bp("reset", 0, 0, 0);
    chk("reset.tag",  64'(bus.OUT_allocTag), 64'd0);
    chk("reset.full", 64'(bus.OUT_full),     64'd0);
`ifdef BUQ_COM_HIST_EN
    chk("reset.comhist", 64'(bus.OUT_comHist), 64'd0);
`endif
    rst = 1'b0;

    //  av an  rv rt rk  cv ct  mv mt  etag evld en etk
    add(1, 0,  0, 0, 0,  0, 0,  0, 0,  0,   0,   0, 0);
    add(1, 1,  0, 0, 0,  0, 0,  0, 0,  1,   0,   0, 0);
    add(1, 2,  0, 0, 0,  0, 0,  0, 0,  2,   0,   0, 0);
    add(0, 0,  1, 1, 1,  0, 0,  0, 0,  3,   0,   0, 0);
    add(0, 0,  1, 0, 0,  0, 0,  0, 0,  3,   0,   0, 0);
    add(0, 0,  1, 2, 1,  0, 0,  0, 0,  3,   0,   0, 0);
    add(0, 0,  0, 0, 0,  1, 2,  0, 0,  3,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  3,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  3,   1,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  3,   1,   1, 1);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  3,   1,   2, 1);
    add(1, 3,  0, 0, 0,  0, 0,  0, 0,  3,   0,   0, 0);
    add(0, 0,  1, 3, 1,  1, 3,  0, 0,  4,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  4,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  4,   1,   3, 1);
    add(1, 4,  0, 0, 0,  0, 0,  0, 0,  4,   0,   0, 0);
    add(1, 5,  0, 0, 0,  0, 0,  0, 0,  5,   0,   0, 0);
    add(1, 6,  0, 0, 0,  0, 0,  0, 0,  6,   0,   0, 0);
    add(1, 7,  0, 0, 0,  0, 0,  0, 0,  7,   0,   0, 0);
    add(1, 8,  0, 0, 0,  0, 0,  0, 0,  8,   0,   0, 0);
    add(1, 9,  0, 0, 0,  0, 0,  0, 0,  9,   0,   0, 0);
    add(1, 10, 1, 8, 1,  0, 0,  1, 6,  10,  0,   0, 0);
    add(1, 11, 0, 0, 0,  0, 0,  0, 0,  7,   0,   0, 0);
    add(0, 0,  1, 8, 1,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  1, 4, 1,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  1, 5, 0,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  1, 6, 1,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  0, 0, 0,  1, 7,  0, 0,  8,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   1,   4, 1);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   1,   5, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   1,   6, 1);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  1, 7, 0,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   0,   0, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   1,  11, 0);
    add(0, 0,  0, 0, 0,  0, 0,  0, 0,  8,   0,   0, 0);

    foreach (vq[i]) begin
      drive(vq[i].av, vq[i].aj, vq[i].an, vq[i].rv, vq[i].rt, vq[i].rk,
            vq[i].cv, vq[i].ct, vq[i].mv, vq[i].mt);
      chk($sformatf("row%0d.tag", i),  64'(bus.OUT_allocTag), 64'(vq[i].etag));
      chk($sformatf("row%0d.full", i), 64'(bus.OUT_full),     64'd0);
      chk_bp($sformatf("row%0d", i), vq[i].evld, vq[i].en, vq[i].etk);
      step();
    end

    // Fill to DEPTH, then a dropped alloc must not overwrite entry 0.
    idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      alloc(100 + k, 0);
      chk($sformatf("fill%0d.tag", k),  64'(bus.OUT_allocTag), 64'(k));
      chk($sformatf("fill%0d.full", k), 64'(bus.OUT_full),     64'd0);
      step();
    end
    alloc(116, 0);
    chk("full.tag",  64'(bus.OUT_allocTag), 64'd16);
    chk("full.full", 64'(bus.OUT_full),     64'd1);
    step();
    chk("drop.tag",  64'(bus.OUT_allocTag), 64'd16);
    chk("drop.full", 64'(bus.OUT_full),     64'd1);
    drive(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    step(); idle();
    chk_bp("full.dec", 0, 0, 0);
    step();
    chk_bp("full.drain", 1, 100, 1);
    chk("full.after", 64'(bus.OUT_full), 64'd0);

    // Reset while the head is about to drain.
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin alloc(300 + k, 0); step(); end
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 1, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, 2, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 2, 0, 0); step();
    idle(); rst = 1'b1; step();
    chk_bp("rst.mid", 0, 0, 0);
    chk("rst.tag",  64'(bus.OUT_allocTag), 64'd0);
    chk("rst.full", 64'(bus.OUT_full),     64'd0);
    rst = 1'b0; step();
    chk_bp("rst.post1", 0, 0, 0);
    step();
    chk_bp("rst.post2", 0, 0, 0);

    // Committed but unresolved head blocks younger resolved entry.
    alloc(400, 0); step();
    alloc(401, 0); step();
    drive(0, 0, 0, 1, 1, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0); step();
    idle();
    for (int k = 0; k < 5; k++) begin
      chk_bp($sformatf("stall%0d", k), 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step(); idle();
    chk_bp("stall.dec", 0, 0, 0);
    step();
    chk_bp("stall.u0", 1, 400, 0);
    step();
    chk_bp("stall.u1", 1, 401, 1);
`ifdef BUQ_COM_HIST_EN
    chk("stall.comhist", 64'(bus.OUT_comHist), 64'd1);
`endif
    step();
    chk_bp("stall.end", 0, 0, 0);

    // Jump is pre-resolved taken and leaves committed history alone.
    alloc(500, 1);
    chk("jump.tag", 64'(bus.OUT_allocTag), 64'd2);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 2, 0, 0); step(); idle();
    chk_bp("jump.dec", 0, 0, 0);
    step();
    chk_bp("jump.upd", 1, 500, 1);
`ifdef BUQ_COM_HIST_EN
    chk("jump.comhist", 64'(bus.OUT_comHist), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-002 Parameter HIST_W, default 16, global-history width.
REQ-003 Parameter BPI_W, default 12, opaque BranchPredInfo width.
REQ-004 Ports SHALL be (name dir width meaning); one clock, reset synchronous active-high:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 IN_allocValid  in  1  new branch, program order
 IN_allocPc  in  31  branch address [31:1]
 IN_allocHist  in  HIST_W  history at prediction
 IN_allocBpi  in  BPI_W  prediction info
 IN_allocIsJump  in  1  unconditional jump
 OUT_allocTag  out  log2(DEPTH)+1  tag for this alloc (wrap bit in MSB)
 OUT_full  out  1  no free entry
 IN_resValid  in  1  branch unit resolved
 IN_resTag  in  log2(DEPTH)+1  resolved tag
 IN_resTaken  in  1  actual direction
 IN_comValid  in  1  ROB committed through tag
 IN_comTag  in  log2(DEPTH)+1  youngest committed tag
 IN_mispr  in  1  mispredict flush
 IN_misprTag  in  log2(DEPTH)+1  mispredicting branch tag
 OUT_bpUpdate  out  1+31+HIST_W+BPI_W+1  {valid, pc, history, bpi, branchTaken}, predictor update port

Function
REQ-005 Circular buffer; head/tail pointers log2(DEPTH)+1 bits; empty = equal; full = same index, wrap bits differ.
REQ-006 OUT_allocTag = tail combinationally; OUT_full combinational from pointers.
REQ-007 Alloc accepted when IN_allocValid && !OUT_full && !IN_mispr: write entry at tail, tail+1 next cycle.
REQ-008 Alloc while full or during IN_mispr SHALL be dropped with no state change; upstream must stall on OUT_full.
REQ-009 Entry flags: resolved, committed, taken; alloc clears committed; jump alloc sets resolved=1, taken=1; otherwise resolved=0.
REQ-010 Resolve sets resolved=1, taken=IN_resTaken when IN_resTag in live window [head,tail); otherwise ignored.
REQ-011 Commit sets committed on every live entry from head through IN_comTag inclusive; tag outside window ignored.
REQ-012 Drain: at most one entry per cycle; head entry leaves when live, resolved and committed; head+1.
REQ-013 OUT_bpUpdate registered: valid the cycle after the drain decision, carrying the drained entry fields; valid=0 otherwise, other fields don't-care.
REQ-014 Latency: alloc, resolve, commit all before cycle N -> OUT_bpUpdate valid at N+1 at earliest.
REQ-015 Committed but unresolved head blocks the drain; younger entries SHALL NOT bypass it.
REQ-016 IN_mispr: tail <= IN_misprTag+1; mispredicting entry kept; younger entries discarded; head and drain unaffected.
REQ-017 Resolve and commit of the same entry in one cycle SHALL both apply.
REQ-018 Resolve of a tag discarded by IN_mispr the same cycle SHALL be ignored.
REQ-019 Drain in a cycle where alloc fills the freed slot SHALL be legal; full is evaluated on pre-update pointers.

Reset
REQ-020 rst: head=tail=0, all flags cleared, OUT_bpUpdate.valid=0, OUT_full=0, OUT_allocTag=0.
REQ-021 rst mid-operation SHALL discard all entries with no OUT_bpUpdate emitted the following cycle; rst overrides IN_mispr and all inputs.

Configuration
REQ-022 Macro BUQ_COM_HIST_EN defined: adds output OUT_comHist (HIST_W); reset 0; on each emitted non-jump update shifts left with branchTaken inserted at LSB, registered with OUT_bpUpdate.
REQ-023 Macro undefined: OUT_comHist port and its logic SHALL be absent; other behaviour identical.

Verification
REQ-024 Alloc tags 0,1,2; resolve 1 taken, 0 not-taken, 2 taken; commit tag 2 -> three updates on consecutive cycles, order 0,1,2, taken 0,1,1.
REQ-025 Alloc 16 entries, no drain -> OUT_full=1, tag 16 (wrap set, index 0); 17th alloc dropped, tail unchanged.
REQ-026 Alloc tags 0..5, IN_mispr tag 2 -> next alloc gets tag 3; resolve tag 4 ignored; commit 3 drains 0..2 only.
REQ-027 Commit tag 1 with tag 0 unresolved -> no update for 5 cycles; resolve 0 -> updates 0 then 1 on next two cycles.
REQ-028 Jump alloc tag 0, commit 0 without resolve -> update with branchTaken=1 two cycles later; with BUQ_COM_HIST_EN OUT_comHist unchanged.
REQ-029 rst asserted with 6 live entries, 3 committed and resolved -> no update next cycle, OUT_allocTag=0, OUT_full=0.
